pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage pipeline. Drives the PC-write,
//  IF/ID write/flush and ID/EX flush/bubble controls, and the EX/MEM hold. Handles
//  load-use stalls, taken-branch redirects and multi-cycle data-memory waits with a timeout.
//  Sits beside the ID stage. Also keeps saturating stall/flush performance counters.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive wait cycles on one data-memory access before error
//  CNT_W        16  width of performance counters
// PORTS
//  clk             in   1      clock
//  reset           in   1      synchronous, active-high
//  id_rs1          in   5      rs1 of instruction in ID
//  id_rs2          in   5      rs2 of instruction in ID
//  id_uses_rs1     in   1      ID instruction reads rs1
//  id_uses_rs2     in   1      ID instruction reads rs2
//  ex_valid        in   1      ID/EX holds a real instruction (not bubble)
//  ex_rd           in   5      rd in ID/EX
//  ex_memread      in   1      ID/EX instruction is a load
//  ex_branch_taken in   1      branch/jump in EX resolved taken this cycle
//  mem_req         in   1      MEM stage instruction accesses data memory
//  mem_ready       in   1      data memory completes access this cycle
//  pc_write        out  1      1 = PC updates
//  ifid_write      out  1      1 = IF/ID captures
//  ifid_flush      out  1      1 = IF/ID cleared
//  idex_flush      out  1      1 = ID/EX cleared (branch redirect)
//  idex_bubble     out  1      1 = ID/EX cleared (load-use bubble)
//  idex_hold       out  1      1 = ID/EX and EX/MEM keep contents
//  mem_err         out  1      sticky: memory timeout occurred
//  stall_cnt       out  CNT_W  cycles with pc_write=0
//  flush_cnt       out  CNT_W  count of branch redirects
// BEHAVIOUR
//  States:
//  - RUN, MEM_WAIT, ERROR. Reset -> RUN.
//  - wait_cnt=0, mem_err=0, counters=0.
//  Control outputs:
//  - Combinational from state and inputs; zero latency. The controls act on the same clock edge.
//  - Defaults: pc_write=1, ifid_write=1, all others 0.
//  - While reset is high, outputs equal these defaults.
//  Priority (highest first), evaluated every cycle:
//   1 ERROR: pc_write=0, ifid_write=0, idex_hold=1; no flushes. Leaves only by reset.
//   2 Memory wait (mem_req & !mem_ready): pc_write=0, ifid_write=0, idex_hold=1; no flush.
//     A branch in EX stays held and is honoured after release.
//   3 Branch (ex_branch_taken): ifid_flush=1, idex_flush=1, pc_write=1. Overrides load-use.
//   4 Load-use:
//     - Condition: ex_valid & ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) |
//       (id_uses_rs2 & id_rs2==ex_rd)).
//     - Response: pc_write=0, ifid_write=0, idex_bubble=1.
//     - Exactly one bubble per load; the next cycle ex_valid=0 clears the hazard.
//  Transitions:
//  - RUN -> MEM_WAIT when mem_req & !mem_ready; wait_cnt <= 1.
//  - MEM_WAIT:
//    - If mem_ready: -> RUN and wait_cnt <= 0. Controls that cycle follow rules 3/4
//      (release is same-cycle).
//    - Else if wait_cnt == MEM_TIMEOUT-1: -> ERROR and mem_err <= 1.
//    - Else wait_cnt++.
//  - mem_req & mem_ready in RUN: no stall, stays RUN.
//  Counters:
//  - stall_cnt += 1 on every cycle with pc_write=0.
//  - flush_cnt += 1 on every cycle with idex_flush=1.
//  - Both saturate at all-ones, with no wrap.
//  Reset mid-operation: reset in MEM_WAIT/ERROR returns to RUN next edge. It clears
//  wait_cnt, mem_err and both counters.
// TESTING
//  T1 load-use:
//  - Stimulus: ex_valid=1, ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1.
//  - Expect: pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_cnt=1.
//  - Stimulus: same but ex_rd=0. Expect: no stall.
//  T2 branch vs load-use:
//  - Stimulus: load-use condition and ex_branch_taken=1 together.
//  - Expect: ifid_flush=1, idex_flush=1, pc_write=1, idex_bubble=0; flush_cnt=1.
//  T3 memory wait:
//  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
//  - Expect: freeze (idex_hold=1) for 3 cycles; release on cycle 4; state RUN; stall_cnt=3.
//  T4 branch held by memory wait:
//  - Stimulus: ex_branch_taken=1 during a 2-cycle wait.
//  - Expect: no flush while frozen; flush pulses once on the release cycle.
//  T5 timeout:
//  - Stimulus: MEM_TIMEOUT=4, mem_req=1, mem_ready never.
//  - Expect: mem_err=1 after 4th wait cycle; frozen.
//  - Stimulus: then mem_ready=1. Expect: stays frozen.
//  - Stimulus: then reset. Expect: mem_err=0, RUN.
//  T6 saturation:
//  - Stimulus: CNT_W=4, hold the stall 20 cycles.
//  - Expect: stall_cnt sticks at 15.
//  - Stimulus: reset. Expect: stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Produces the PC, IF/ID, ID/EX and EX/MEM control strobes combinationally from the
// current state and the ID/EX/MEM inputs. The strobes handle load-use bubbles,
// taken-branch redirects and data-memory waits. A memory access that never completes
// is caught by a timeout. The block also keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // wait_cnt only ever needs to reach MEM_TIMEOUT-1
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_err_q, mem_err_nxt;
  logic              frozen;
  logic              load_use;

  // A load in EX whose destination is read by the instruction in ID
  assign load_use = ex_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Next-state and control outputs: freeze first, then branch, then load-use
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    mem_err_nxt = mem_err_q;
    frozen      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;

    if (!reset) begin
      unique case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            frozen    = 1'b1;
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // Release is same-cycle: the pipeline advances on the mem_ready cycle
          if (mem_ready) begin
            state_nxt = RUN;
            wait_nxt  = '0;
          end else begin
            frozen = 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              state_nxt   = ERROR;
              mem_err_nxt = 1'b1;
            end else begin
              wait_nxt = wait_cnt + WAIT_W'(1);
            end
          end
        end
        ERROR: begin
          frozen = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase

      // A frozen pipeline keeps a taken branch in EX; it is honoured after release
      if (frozen) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_hold  = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // The sticky error flag reads as 0 while reset is asserted, like every other control
  assign mem_err = mem_err_q && !reset;

  // State, wait counter and sticky error register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

  // Saturating performance counters: stalled cycles and branch redirects
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (idex_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Tests stage inputs and push the expected control vector for that cycle. The inputs
// are applied on the falling edge and a monitor compares the controls 2 ns later.
// Counter values are compared inline by each test.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Control vector: {pc_write, ifid_write, ifid_flush, idex_flush, idex_bubble, idex_hold, mem_err}
  localparam logic [6:0] C_DEF = 7'b1100000;
  localparam logic [6:0] C_BUB = 7'b0000100;
  localparam logic [6:0] C_BR  = 7'b1111000;
  localparam logic [6:0] C_FRZ = 7'b0000010;
  localparam logic [6:0] C_ERR = 7'b0000011;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, ev;
    logic [4:0] rd;
    logic       mr, bt, mreq, mrdy;
  } stim_t;

  typedef struct {
    logic [6:0] ctrl;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset, id_uses_rs1, id_uses_rs2, ex_valid, ex_memread, ex_branch_taken;
  logic mem_req, mem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_write, ifid_write, ifid_flush, idex_flush, idex_bubble, idex_hold, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  stim_t      nxt;
  exp_t       sb[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .idex_bubble(idex_bubble), .idex_hold(idex_hold),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Scoreboard monitor: one expected control vector per falling edge
  initial begin
    exp_t e;
    logic [6:0] obs;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        obs = {pc_write, ifid_write, ifid_flush, idex_flush, idex_bubble, idex_hold, mem_err};
        n_total++;
        if (obs !== e.ctrl) $display("FAIL %s: controls got %b expected %b", e.tag, obs, e.ctrl);
        else n_pass++;
      end
    end
  end

  task automatic clear_stim();
    nxt = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, ev: 1'b0, rd: 5'd0,
            mr: 1'b0, bt: 1'b0, mreq: 1'b0, mrdy: 1'b0};
  endtask

  // Apply the staged inputs for one cycle and push what that cycle must produce
  task automatic cyc(input logic [6:0] ctrl, input string tag);
    exp_t e;
    @(negedge clk);
    reset = nxt.rst; id_rs1 = nxt.rs1; id_rs2 = nxt.rs2;
    id_uses_rs1 = nxt.u1; id_uses_rs2 = nxt.u2; ex_valid = nxt.ev; ex_rd = nxt.rd;
    ex_memread = nxt.mr; ex_branch_taken = nxt.bt; mem_req = nxt.mreq; mem_ready = nxt.mrdy;
    e.ctrl = ctrl;
    e.tag  = tag;
    sb.push_back(e);
    if (nxt.rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!ctrl[6] && exp_stall != CNT_MAX) exp_stall = exp_stall + 1'b1;
      if (ctrl[3] && exp_flush != CNT_MAX) exp_flush = exp_flush + 1'b1;
    end
  endtask

  task automatic do_reset();
    clear_stim();
    nxt.rst = 1'b1;
    cyc(C_DEF, "reset_outputs");
    cyc(C_DEF, "reset_outputs2");
    clear_stim();
  endtask

  // Idle one cycle, then compare counters (they reflect every cycle driven before this one)
  task automatic idle_check_counters(input string tag);
    clear_stim();
    cyc(C_DEF, {tag, "_idle"});
    #1;
    n_total++;
    if (stall_cnt !== exp_stall) $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, exp_stall);
    else n_pass++;
    n_total++;
    if (flush_cnt !== exp_flush) $display("FAIL %s flush_cnt: got %0d expected %0d", tag, flush_cnt, exp_flush);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    idle_check_counters("reset");
    n_total++;
    if (mem_err !== 1'b0) $display("FAIL reset mem_err: got %b expected 0", mem_err);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    clear_stim();
    nxt.ev = 1'b1; nxt.mr = 1'b1; nxt.rd = 5'd5; nxt.rs2 = 5'd5; nxt.u2 = 1'b1;
    cyc(C_BUB, "lu_rs2_bubble");
    nxt.ev = 1'b0;
    cyc(C_DEF, "lu_cleared_next");
    idle_check_counters("lu_one_bubble");
    // rd = x0 never hazards
    clear_stim();
    nxt.ev = 1'b1; nxt.mr = 1'b1; nxt.rd = 5'd0; nxt.rs2 = 5'd0; nxt.u2 = 1'b1;
    cyc(C_DEF, "lu_rd_zero");
    // rs1 path
    nxt.rd = 5'd7; nxt.rs1 = 5'd7; nxt.u1 = 1'b1; nxt.u2 = 1'b0;
    cyc(C_BUB, "lu_rs1_bubble");
    // match but register not read
    nxt.u1 = 1'b0;
    cyc(C_DEF, "lu_not_used");
    // not a load
    nxt.u1 = 1'b1; nxt.mr = 1'b0;
    cyc(C_DEF, "lu_not_load");
    idle_check_counters("lu_total");
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    clear_stim();
    nxt.ev = 1'b1; nxt.mr = 1'b1; nxt.rd = 5'd5; nxt.rs2 = 5'd5; nxt.u2 = 1'b1; nxt.bt = 1'b1;
    cyc(C_BR, "branch_over_lu");
    idle_check_counters("branch");
  endtask

  task automatic test_mem_wait();
    do_reset();
    clear_stim();
    nxt.mreq = 1'b1;
    for (int i = 0; i < 3; i++) cyc(C_FRZ, "mem_wait_freeze");
    nxt.mrdy = 1'b1;
    cyc(C_DEF, "mem_release");
    // back in RUN: a ready access does not stall
    cyc(C_DEF, "mem_ready_in_run");
    idle_check_counters("mem_wait");
    // wait count restarted: another 3-cycle wait must not time out
    clear_stim();
    nxt.mreq = 1'b1;
    for (int i = 0; i < 3; i++) cyc(C_FRZ, "mem_wait2_freeze");
    nxt.mrdy = 1'b1;
    cyc(C_DEF, "mem_release2");
    idle_check_counters("mem_wait2");
  endtask

  task automatic test_branch_held();
    do_reset();
    clear_stim();
    nxt.mreq = 1'b1; nxt.bt = 1'b1;
    cyc(C_FRZ, "branch_held1");
    cyc(C_FRZ, "branch_held2");
    nxt.mrdy = 1'b1;
    cyc(C_BR, "branch_on_release");
    idle_check_counters("branch_held");
  endtask

  task automatic test_timeout();
    do_reset();
    clear_stim();
    nxt.mreq = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) cyc(C_FRZ, "timeout_wait");
    cyc(C_ERR, "timeout_error");
    nxt.mrdy = 1'b1; nxt.bt = 1'b1;
    cyc(C_ERR, "error_ignores_ready");
    cyc(C_ERR, "error_sticky");
    clear_stim();
    nxt.rst = 1'b1;
    nxt.mreq = 1'b1;
    cyc(C_DEF, "reset_in_error");
    idle_check_counters("after_error_reset");
    // RUN again: a short wait freezes and releases normally
    clear_stim();
    nxt.mreq = 1'b1;
    cyc(C_FRZ, "run_after_reset_wait");
    nxt.mrdy = 1'b1;
    cyc(C_DEF, "run_after_reset_release");
  endtask

  task automatic test_saturation();
    do_reset();
    clear_stim();
    nxt.ev = 1'b1; nxt.mr = 1'b1; nxt.rd = 5'd9; nxt.rs1 = 5'd9; nxt.u1 = 1'b1;
    for (int i = 0; i < 20; i++) cyc(C_BUB, "sat_stall");
    idle_check_counters("saturation");
    n_total++;
    if (stall_cnt !== 4'd15) $display("FAIL sat_value stall_cnt: got %0d expected 15", stall_cnt);
    else n_pass++;
    do_reset();
    idle_check_counters("sat_reset");
  endtask

  initial begin
    clear_stim();
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_rd = '0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_branch_held();
    test_timeout();
    test_saturation();
    @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
